// File: rtl/eth_parser_pkg.sv
// Shared types and constants for the Ethernet parser front end.
// Contents:
//   arb_state_t   - ingress arbiter FSM states (ARB_IDLE, ARB_GRANT)
//   ARB_CNT_WIDTH - width of the per-port granted-frame counters
//   rr_wrap()     - (base + off) mod n for round-robin scans, where
//                   base < n and off <= n
package eth_parser_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  localparam int ARB_CNT_WIDTH = 32;

  // Both operands are bounded, so one conditional subtract replaces a divider.
  function automatic int rr_wrap(input int base, input int off, input int n);
    int s;
    s = base + off;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage

// File: rtl/eth_ingress_arbiter_rr_priority_select.sv
// rr_priority_select: combinational round-robin picker.
// Scans last_idx+1, last_idx+2, ... (mod NUM_PORTS). It returns the first
// requester it finds in that order.
// Ports:
//   req       in  NUM_PORTS  request vector
//   last_idx  in  PORT_W     most recently served index
//   grant_idx out PORT_W     selected index (0 when nothing requests)
//   any_req   out 1          at least one request bit is set
module rr_priority_select
  import eth_parser_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int PORT_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PORT_W-1:0]    last_idx,
  output logic [PORT_W-1:0]    grant_idx,
  output logic                 any_req
);

  logic [PORT_W-1:0] cand;

  // Walk from the farthest offset back to the nearest one. The last hit
  // therefore becomes the closest requester after last_idx.
  always_comb begin
    grant_idx = '0;
    cand      = '0;
    any_req   = |req;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      cand = PORT_W'(rr_wrap(int'(last_idx), k, NUM_PORTS));
      if (req[cand]) grant_idx = cand;
    end
  end

endmodule

// File: rtl/eth_ingress_arbiter.sv
// eth_ingress_arbiter: frame-granular round-robin mux. It shares the parser's
// single AXI-stream input among NUM_PORTS sources. A granted port keeps the
// output until its tlast beat handshakes, so frames never interleave. The
// arbiter spends one IDLE cycle between frames to choose the next port.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   s_tdata/tvalid/tlast/tready   flattened per-port source streams
//   m_tdata/tvalid/tlast/tready   muxed stream toward the parser
//   m_tid            index of the port owning the beat (holds while idle)
//   grant_active     high while a frame is in progress
//   frames_granted   per-port 32-bit grant counters. This port exists only
//                    when the ETH_ARB_FRAME_CNT_EN macro is defined.
module eth_ingress_arbiter
  import eth_parser_pkg::*;
#(
  parameter  int NUM_PORTS  = 4,
  parameter  int DATA_WIDTH = 64,
  localparam int PORT_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_PORTS-1:0]            s_tvalid,
  output logic [NUM_PORTS-1:0]            s_tready,
  input  logic [NUM_PORTS-1:0]            s_tlast,
  output logic [DATA_WIDTH-1:0]           m_tdata,
  output logic                            m_tvalid,
  input  logic                            m_tready,
  output logic                            m_tlast,
  output logic [PORT_W-1:0]               m_tid,
  output logic                            grant_active
`ifdef ETH_ARB_FRAME_CNT_EN
  ,
  output logic [NUM_PORTS*ARB_CNT_WIDTH-1:0] frames_granted
`endif
);

  arb_state_t        state_q, state_d;
  logic [PORT_W-1:0] grant_idx_q, grant_idx_d;
  logic [PORT_W-1:0] last_idx_q, last_idx_d;
  logic [PORT_W-1:0] sel_idx;
  logic              any_req;

  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] s_data_arr;
  assign s_data_arr = s_tdata;

  rr_priority_select #(.NUM_PORTS(NUM_PORTS), .PORT_W(PORT_W)) u_sel (
    .req       (s_tvalid),
    .last_idx  (last_idx_q),
    .grant_idx (sel_idx),
    .any_req   (any_req)
  );

  // grant_idx_q only changes when a new grant is taken. It therefore already
  // holds the last owner through the IDLE bubble.
  assign m_tid = grant_idx_q;

  always_comb begin
    state_d      = state_q;
    grant_idx_d  = grant_idx_q;
    last_idx_d   = last_idx_q;
    m_tvalid     = 1'b0;
    m_tlast      = 1'b0;
    m_tdata      = '0;
    s_tready     = '0;
    grant_active = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (any_req) begin
          grant_idx_d = sel_idx;
          state_d     = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        grant_active          = 1'b1;
        m_tvalid              = s_tvalid[grant_idx_q];
        m_tlast               = s_tlast[grant_idx_q];
        m_tdata               = s_data_arr[grant_idx_q];
        s_tready[grant_idx_q] = m_tready;
        // Only the frame's final handshake releases the grant. A stalled
        // source keeps ownership indefinitely.
        if (m_tvalid && m_tready && m_tlast) begin
          last_idx_d = grant_idx_q;
          state_d    = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // last_idx resets to the top port, so the first scan starts at port 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      grant_idx_q <= '0;
      last_idx_q  <= PORT_W'(NUM_PORTS - 1);
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
      last_idx_q  <= last_idx_d;
    end
  end

`ifdef ETH_ARB_FRAME_CNT_EN
  logic [NUM_PORTS-1:0][ARB_CNT_WIDTH-1:0] cnt_q, cnt_d;

  // Count on the IDLE->GRANT edge. The counters wrap freely.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ARB_IDLE && any_req)
      cnt_d[sel_idx] = cnt_q[sel_idx] + ARB_CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign frames_granted = cnt_q;
`endif

endmodule

// File: tb/tb_eth_ingress_arbiter.sv
// Self-checking bench for eth_ingress_arbiter (NUM_PORTS=4, DATA_WIDTH=64).
// The directed scenarios follow the block's key behaviours. A randomized
// run then compares the DUT against a frame-level round-robin model.
// The frame-counter checks are compiled in when ETH_ARB_FRAME_CNT_EN is
// defined.
module tb_eth_ingress_arbiter;
  localparam int NP = 4;
  localparam int DW = 64;
  localparam int PW = 2;
  localparam int CW = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NP*DW-1:0] s_tdata;
  logic [NP-1:0]    s_tvalid, s_tready, s_tlast;
  logic [DW-1:0]    m_tdata;
  logic             m_tvalid, m_tready, m_tlast;
  logic [PW-1:0]    m_tid;
  logic             grant_active;
`ifdef ETH_ARB_FRAME_CNT_EN
  logic [NP*CW-1:0] frames_granted;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  eth_ingress_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .s_tdata      (s_tdata),
    .s_tvalid     (s_tvalid),
    .s_tready     (s_tready),
    .s_tlast      (s_tlast),
    .m_tdata      (m_tdata),
    .m_tvalid     (m_tvalid),
    .m_tready     (m_tready),
    .m_tlast      (m_tlast),
    .m_tid        (m_tid),
    .grant_active (grant_active)
`ifdef ETH_ARB_FRAME_CNT_EN
    ,
    .frames_granted (frames_granted)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input int p, input logic v, input logic l, input logic [DW-1:0] d);
    s_tvalid[p]         = v;
    s_tlast[p]          = l;
    s_tdata[p*DW +: DW] = d;
  endtask

  function automatic logic [DW-1:0] pat(input int p, input int b);
    return {32'(p + 1) ^ 32'h5A00_0000, 32'(b) ^ 32'hC0DE_0000};
  endfunction

  // Reference arbitration: scan upward from the last served port, wrapping at NP.
  function automatic int rr_pick(input int lastp, input logic [NP-1:0] req);
    for (int k = 1; k <= NP; k++)
      if (req[(lastp + k) % NP]) return (lastp + k) % NP;
    return -1;
  endfunction

  task automatic apply_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    s_tvalid = '0; s_tlast = '0; s_tdata = '0; m_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if ({grant_active, m_tvalid, m_tlast, m_tid, s_tready} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %b want 0", {grant_active, m_tvalid, m_tlast, m_tid, s_tready});
    end
`ifdef ETH_ARB_FRAME_CNT_EN
    n_checks++;
    if (frames_granted !== '0) begin
      n_fail++; $display("FAIL reset_counters: got %h want 0", frames_granted);
    end
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_single_port();
    m_tready = 1'b1;
    set_beat(2, 1'b1, 1'b0, pat(2, 0));
    @(negedge clk);
    n_checks++;
    if ({grant_active, m_tvalid, s_tready} !== '0) begin
      n_fail++; $display("FAIL single_idle: got %b want 0", {grant_active, m_tvalid, s_tready});
    end
    for (int b = 0; b < 3; b++) begin
      next_cyc();
      if (b > 0) set_beat(2, 1'b1, 1'(b == 2), pat(2, b));
      @(negedge clk);
      n_checks++;
      if ({grant_active, m_tvalid, m_tid, m_tlast, s_tready} !== {1'b1, 1'b1, 2'd2, 1'(b == 2), 4'b0100}) begin
        n_fail++; $display("FAIL single_beat%0d_ctl: got %b want %b", b, {grant_active, m_tvalid, m_tid, m_tlast, s_tready}, {1'b1, 1'b1, 2'd2, 1'(b == 2), 4'b0100});
      end
      n_checks++;
      if (m_tdata !== pat(2, b)) begin
        n_fail++; $display("FAIL single_beat%0d_data: got %h want %h", b, m_tdata, pat(2, b));
      end
    end
    next_cyc();
    set_beat(2, 1'b0, 1'b0, '0);
    @(negedge clk);
    n_checks++;
    if ({grant_active, m_tid} !== {1'b0, 2'd2}) begin
      n_fail++; $display("FAIL single_release: got %b want 010", {grant_active, m_tid});
    end
  endtask

  task automatic test_round_robin();
    logic [NP-1:0] hsv;
    int bidx[NP];
    int p;
    apply_reset();
    for (int i = 0; i < NP; i++) begin
      bidx[i] = 0;
      set_beat(i, 1'b1, 1'b0, pat(i, 0));
    end
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      hsv = s_tvalid & s_tready;
      p = (c / 3) % NP;
      n_checks++;
      if (c % 3 == 0) begin
        if (grant_active !== 1'b0) begin
          n_fail++; $display("FAIL rr_bubble_c%0d: got ga=%b want 0", c, grant_active);
        end
      end else if ({grant_active, m_tid, m_tlast, m_tdata} !== {1'b1, PW'(p), 1'(c % 3 == 2), pat(p, c % 3 - 1)}) begin
        n_fail++; $display("FAIL rr_grant_c%0d: got ga=%b tid=%0d last=%b data=%h want tid=%0d", c, grant_active, m_tid, m_tlast, m_tdata, p);
      end
      next_cyc();
      for (int i = 0; i < NP; i++)
        if (hsv[i]) begin
          bidx[i] ^= 1;
          set_beat(i, 1'b1, 1'(bidx[i] == 1), pat(i, bidx[i]));
        end
    end
  endtask

  task automatic test_valid_gap();
    apply_reset();
    set_beat(1, 1'b1, 1'b0, pat(1, 0));
    @(negedge clk);
    next_cyc();
    set_beat(0, 1'b1, 1'b1, pat(0, 0));
    @(negedge clk);
    n_checks++;
    if ({grant_active, m_tid, m_tvalid, s_tready} !== {1'b1, 2'd1, 1'b1, 4'b0010}) begin
      n_fail++; $display("FAIL gap_grant1: got %b want 1011_0010", {grant_active, m_tid, m_tvalid, s_tready});
    end
    next_cyc();
    set_beat(1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) next_cyc();
      @(negedge clk);
      n_checks++;
      if ({grant_active, m_tid, m_tvalid, s_tready} !== {1'b1, 2'd1, 1'b0, 4'b0010}) begin
        n_fail++; $display("FAIL gap_hold%0d: got %b want 1010_0010", i, {grant_active, m_tid, m_tvalid, s_tready});
      end
    end
    next_cyc();
    set_beat(1, 1'b1, 1'b0, pat(1, 1));
    @(negedge clk);
    n_checks++;
    if ({m_tid, m_tvalid, m_tdata} !== {2'd1, 1'b1, pat(1, 1)}) begin
      n_fail++; $display("FAIL gap_resume: got tid=%0d v=%b data=%h want tid=1 data=%h", m_tid, m_tvalid, m_tdata, pat(1, 1));
    end
    next_cyc();
    set_beat(1, 1'b1, 1'b1, pat(1, 2));
    @(negedge clk);
    n_checks++;
    if ({m_tid, m_tlast, s_tready} !== {2'd1, 1'b1, 4'b0010}) begin
      n_fail++; $display("FAIL gap_last: got %b want 01_1_0010", {m_tid, m_tlast, s_tready});
    end
    next_cyc();
    set_beat(1, 1'b0, 1'b0, '0);
    @(negedge clk);
    n_checks++;
    if (grant_active !== 1'b0) begin
      n_fail++; $display("FAIL gap_bubble: got ga=%b want 0", grant_active);
    end
    next_cyc();
    @(negedge clk);
    n_checks++;
    if ({grant_active, m_tid, m_tlast, s_tready, m_tdata} !== {1'b1, 2'd0, 1'b1, 4'b0001, pat(0, 0)}) begin
      n_fail++; $display("FAIL gap_port0: got ga=%b tid=%0d rdy=%b data=%h want tid=0 rdy=0001", grant_active, m_tid, s_tready, m_tdata);
    end
    next_cyc();
    set_beat(0, 1'b0, 1'b0, '0);
  endtask

  task automatic test_backpressure();
    int nhs;
    nhs = 0;
    apply_reset();
    set_beat(3, 1'b1, 1'b0, pat(3, 0));
    @(negedge clk);
    next_cyc();
    @(negedge clk);
    nhs += int'(m_tvalid && m_tready);
    n_checks++;
    if ({grant_active, m_tid, m_tdata} !== {1'b1, 2'd3, pat(3, 0)}) begin
      n_fail++; $display("FAIL bp_first: got ga=%b tid=%0d data=%h want tid=3", grant_active, m_tid, m_tdata);
    end
    next_cyc();
    set_beat(3, 1'b1, 1'b0, pat(3, 1));
    m_tready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) next_cyc();
      @(negedge clk);
      nhs += int'(m_tvalid && m_tready);
      n_checks++;
      if ({m_tvalid, m_tlast, s_tready, m_tid, m_tdata} !== {1'b1, 1'b0, 4'b0000, 2'd3, pat(3, 1)}) begin
        n_fail++; $display("FAIL bp_stall%0d: got v=%b l=%b rdy=%b tid=%0d data=%h", i, m_tvalid, m_tlast, s_tready, m_tid, m_tdata);
      end
    end
    next_cyc();
    m_tready = 1'b1;
    @(negedge clk);
    nhs += int'(m_tvalid && m_tready);
    n_checks++;
    if ({s_tready, m_tdata} !== {4'b1000, pat(3, 1)}) begin
      n_fail++; $display("FAIL bp_release: got rdy=%b data=%h want 1000 %h", s_tready, m_tdata, pat(3, 1));
    end
    next_cyc();
    set_beat(3, 1'b1, 1'b1, pat(3, 2));
    @(negedge clk);
    nhs += int'(m_tvalid && m_tready);
    n_checks++;
    if ({m_tlast, m_tdata} !== {1'b1, pat(3, 2)}) begin
      n_fail++; $display("FAIL bp_last: got l=%b data=%h", m_tlast, m_tdata);
    end
    next_cyc();
    set_beat(3, 1'b0, 1'b0, '0);
    @(negedge clk);
    n_checks++;
    if (nhs !== 3 || grant_active !== 1'b0) begin
      n_fail++; $display("FAIL bp_beats: got %0d handshakes ga=%b want 3 ga=0", nhs, grant_active);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    set_beat(2, 1'b1, 1'b1, pat(2, 0));
    @(negedge clk);
    next_cyc();
    @(negedge clk);
    n_checks++;
    if ({grant_active, m_tid, m_tlast} !== {1'b1, 2'd2, 1'b1}) begin
      n_fail++; $display("FAIL wrap_p2: got %b want 1101", {grant_active, m_tid, m_tlast});
    end
    next_cyc();
    set_beat(2, 1'b0, 1'b0, '0);
    set_beat(3, 1'b1, 1'b1, pat(3, 0));
    set_beat(0, 1'b1, 1'b1, pat(0, 0));
    @(negedge clk);
    next_cyc();
    @(negedge clk);
    n_checks++;
    if ({grant_active, m_tid, m_tdata} !== {1'b1, 2'd3, pat(3, 0)}) begin
      n_fail++; $display("FAIL wrap_p3: got ga=%b tid=%0d want tid=3", grant_active, m_tid);
    end
    next_cyc();
    set_beat(3, 1'b0, 1'b0, '0);
    @(negedge clk);
    next_cyc();
    @(negedge clk);
    n_checks++;
    if ({grant_active, m_tid, m_tdata} !== {1'b1, 2'd0, pat(0, 0)}) begin
      n_fail++; $display("FAIL wrap_p0: got ga=%b tid=%0d want tid=0", grant_active, m_tid);
    end
    next_cyc();
    set_beat(0, 1'b0, 1'b0, '0);
  endtask

  task automatic test_reset_midframe();
    apply_reset();
    set_beat(1, 1'b1, 1'b0, pat(1, 0));
    @(negedge clk);
    next_cyc();
    @(negedge clk);
    n_checks++;
    if ({grant_active, m_tid} !== {1'b1, 2'd1}) begin
      n_fail++; $display("FAIL rstmid_grant: got %b want 101", {grant_active, m_tid});
    end
    next_cyc();
    set_beat(1, 1'b1, 1'b0, pat(1, 1));
    set_beat(0, 1'b1, 1'b1, pat(0, 0));
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({grant_active, m_tvalid, m_tlast, m_tid, s_tready} !== '0) begin
      n_fail++; $display("FAIL rstmid_async: got %b want 0", {grant_active, m_tvalid, m_tlast, m_tid, s_tready});
    end
`ifdef ETH_ARB_FRAME_CNT_EN
    n_checks++;
    if (frames_granted !== '0) begin
      n_fail++; $display("FAIL rstmid_cnt_zero: got %h want 0", frames_granted);
    end
`endif
    next_cyc();
    rst = 1'b0;
    @(negedge clk);
    next_cyc();
    @(negedge clk);
    n_checks++;
    if ({grant_active, m_tid, m_tdata} !== {1'b1, 2'd0, pat(0, 0)}) begin
      n_fail++; $display("FAIL rstmid_p0_first: got ga=%b tid=%0d want tid=0", grant_active, m_tid);
    end
`ifdef ETH_ARB_FRAME_CNT_EN
    n_checks++;
    if (frames_granted !== {32'd0, 32'd0, 32'd0, 32'd1}) begin
      n_fail++; $display("FAIL rstmid_cnt_one: got %h want port0=1", frames_granted);
    end
`endif
  endtask

  task automatic test_random();
    int            rem[NP];
    int            fseq[NP];
    int            grants[NP];
    int            owner, lastp, total;
    logic          busy;
    logic [NP-1:0] hsv, exp_rdy;
    apply_reset();
    busy = 1'b0; owner = 0; lastp = NP - 1; hsv = '0;
    for (int i = 0; i < NP; i++) begin
      rem[i] = 0; fseq[i] = 0; grants[i] = 0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < NP; i++) begin
        if (hsv[i]) begin
          rem[i]--;
          if (rem[i] == 0) fseq[i]++;
        end
        // A presented beat stays put until it is accepted.
        if (!(s_tvalid[i] && !hsv[i])) begin
          if (rem[i] == 0 && $urandom_range(2) == 0) rem[i] = int'($urandom_range(4, 1));
          if (rem[i] > 0 && $urandom_range(3) != 0)
            set_beat(i, 1'b1, 1'(rem[i] == 1), {8'(i), 24'(fseq[i]), 32'($urandom())});
          else
            set_beat(i, 1'b0, 1'b0, '0);
        end
      end
      m_tready = ($urandom_range(3) != 0);
      @(negedge clk);
      hsv = s_tvalid & s_tready;
      if (!busy) begin
        n_checks++;
        if ({grant_active, m_tvalid, s_tready, m_tid} !== {1'b0, 1'b0, 4'b0000, PW'(owner)}) begin
          n_fail++; $display("FAIL rnd_idle_c%0d: got ga=%b v=%b rdy=%b tid=%0d want tid=%0d", cyc, grant_active, m_tvalid, s_tready, m_tid, owner);
        end
        if (|s_tvalid) begin
          owner = rr_pick(lastp, s_tvalid);
          busy  = 1'b1;
          grants[owner]++;
        end
      end else begin
        exp_rdy = '0;
        exp_rdy[owner] = m_tready;
        n_checks++;
        if ({grant_active, m_tid, m_tvalid, s_tready} !== {1'b1, PW'(owner), s_tvalid[owner], exp_rdy}) begin
          n_fail++; $display("FAIL rnd_grant_c%0d: got ga=%b tid=%0d v=%b rdy=%b want tid=%0d rdy=%b", cyc, grant_active, m_tid, m_tvalid, s_tready, owner, exp_rdy);
        end
        if (s_tvalid[owner]) begin
          n_checks++;
          if ({m_tdata, m_tlast} !== {s_tdata[owner*DW +: DW], s_tlast[owner]}) begin
            n_fail++; $display("FAIL rnd_data_c%0d: got %h/%b want %h/%b", cyc, m_tdata, m_tlast, s_tdata[owner*DW +: DW], s_tlast[owner]);
          end
          if (m_tready && s_tlast[owner]) begin
            lastp = owner;
            busy  = 1'b0;
          end
        end
      end
      next_cyc();
    end
    total = 0;
    for (int i = 0; i < NP; i++) total += grants[i];
    n_checks++;
    if (total < 100) begin
      n_fail++; $display("FAIL rnd_progress: got %0d frames want >= 100", total);
    end
`ifdef ETH_ARB_FRAME_CNT_EN
    for (int i = 0; i < NP; i++) begin
      n_checks++;
      if (frames_granted[i*CW +: CW] !== 32'(grants[i])) begin
        n_fail++; $display("FAIL rnd_cnt_p%0d: got %0d want %0d", i, frames_granted[i*CW +: CW], grants[i]);
      end
    end
`endif
  endtask

  initial begin
    s_tvalid = '0; s_tlast = '0; s_tdata = '0; m_tready = 1'b0;
    test_reset();
    test_single_port();
    test_round_robin();
    test_valid_gap();
    test_backpressure();
    test_wrap();
    test_reset_midframe();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
